noc_yx_packet_injector: RTL and testbench

//  Local-port transmitter of the YX mesh NoC: turns core send requests into header/body/tail flits
//  for the attached router's local input port.

---
 rtl/noc_yx_packet_injector.sv | 144 ++++++++++++++
 tb/tb_noc_yx_packet_injector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_yx_packet_injector.sv
// Local-port packet injector for the YX mesh NoC: request -> HEAD, BODY..., TAIL flits.
// Optional packet counter built only when NOC_INJ_PKTCNT_EN is defined.
module noc_yx_packet_injector #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        router_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_dest_i,
    input  logic [LEN_W-1:0]  req_len_i,
    input  logic              pld_valid_i,
    output logic              pld_ready_o,
    input  logic [DATA_W-1:0] pld_data_i,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic [DATA_W+1:0] flit_data_o,
    output logic              busy_o,
    output logic              len_err_o,
    output logic [15:0]       pkt_count_o
);
    localparam logic [1:0]       FT_HEAD   = 2'b00;
    localparam logic [1:0]       FT_BODY   = 2'b01;
    localparam logic [1:0]       FT_TAIL   = 2'b10;
    localparam logic [1:0]       FT_HT     = 2'b11;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY} state_e;

    state_e            state_q, state_d;
    logic [7:0]        dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              len_err_q, len_err_d;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        head_data                = '0;
        head_data[7:0]           = dest_q;
        head_data[15:8]          = router_addr_i;
        head_data[15+LEN_W:16]   = len_q;
    end

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        len_d        = len_q;
        rem_d        = rem_q;
        len_err_d    = 1'b0;
        req_ready_o  = 1'b0;
        pld_ready_o  = 1'b0;
        flit_valid_o = 1'b0;
        flit_data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    dest_d  = req_dest_i;
                    state_d = ST_HEAD;
                    if (req_len_i > MAX_LEN_L) begin
                        len_d     = MAX_LEN_L;
                        len_err_d = 1'b1;
                    end else begin
                        len_d = req_len_i;
                    end
                end
            end
            ST_HEAD: begin
                flit_valid_o = 1'b1;
                flit_data_o  = {(len_q == '0) ? FT_HT : FT_HEAD, head_data};
                if (flit_ready_i) begin
                    rem_d   = len_q;
                    state_d = (len_q == '0) ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                // Payload passes straight through; the router's ready is the core's ready.
                flit_valid_o = pld_valid_i;
                pld_ready_o  = flit_ready_i;
                flit_data_o  = {(rem_q == ONE_L) ? FT_TAIL : FT_BODY, pld_data_i};
                if (pld_valid_i && flit_ready_i) begin
                    rem_d = rem_q - ONE_L;
                    if (rem_q == ONE_L) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst_ni) begin
            req_ready_o  = 1'b0;
            pld_ready_o  = 1'b0;
            flit_valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            len_err_q <= len_err_d;
        end
    end

    assign busy_o    = rst_ni && (state_q != ST_IDLE);
    assign len_err_o = len_err_q;

`ifdef NOC_INJ_PKTCNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic        pkt_done;

    // TAIL and HEAD+TAIL are the only flit types with the upper type bit set.
    assign pkt_done = flit_valid_o && flit_ready_i && flit_data_o[DATA_W+1];

    always_comb begin
        pkt_cnt_d = pkt_done ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_count_o = pkt_cnt_q;
`else
    assign pkt_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_noc_yx_packet_injector.sv
// Randomized self-checking bench for noc_yx_packet_injector against a packet-level flit model.
module tb_noc_yx_packet_injector;
    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        router_addr;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_dest;
    logic [LEN_W-1:0]  req_len;
    logic              pld_valid;
    logic              pld_ready;
    logic [DATA_W-1:0] pld_data;
    logic              flit_valid;
    logic              flit_ready;
    logic [DATA_W+1:0] flit_data;
    logic              busy;
    logic              len_err;
    logic [15:0]       pkt_count;

    int          total = 0;
    int          bad   = 0;
    int          exp_cnt = 0;
    logic [33:0] first_flit;

    always #5 clk = ~clk;

    noc_yx_packet_injector #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .router_addr_i(router_addr),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_dest_i   (req_dest),
        .req_len_i    (req_len),
        .pld_valid_i  (pld_valid),
        .pld_ready_o  (pld_ready),
        .pld_data_i   (pld_data),
        .flit_valid_o (flit_valid),
        .flit_ready_i (flit_ready),
        .flit_data_o  (flit_data),
        .busy_o       (busy),
        .len_err_o    (len_err),
        .pkt_count_o  (pkt_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_pkt_count();
`ifdef NOC_INJ_PKTCNT_EN
        check("pkt_count", 64'(pkt_count), 64'(exp_cnt));
`else
        check("pkt_count", 64'(pkt_count), 64'd0);
`endif
    endtask

    // mode 0: ready/valid always high, 1: ready toggles 1010 with payload gaps, 2: fully random.
    // abort_after >= 0 stops once that many flits have been sampled as accepted.
    task automatic send_packet(input logic [7:0] dest, input logic [3:0] len,
                               input int mode, input int abort_after);
        logic [33:0] exp_q[$];
        logic [31:0] words[$];
        int          eff;
        int          n;
        int          idx = 0;
        int          cycles = 0;
        int          err_cycles = 0;
        int          head_cyc = 0;
        int          tail_cyc = 0;
        bit          accepted = 0;
        bit          consumed = 0;
        bit          prev_stall = 0;
        logic [33:0] prev_data = '0;

        eff = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        exp_q.push_back((34'((eff == 0) ? 3 : 0) << 32) | 34'(dest)
                        | (34'(router_addr) << 8) | (34'(eff) << 16));
        for (int i = 0; i < int'(len); i++) begin
            words.push_back($urandom);
            if (i < eff) begin
                exp_q.push_back((34'((i == eff - 1) ? 2 : 1) << 32) | 34'(words[i]));
            end
        end
        n = exp_q.size();

        pld_valid = 1'b0;
        while (idx < n && cycles < 400 && idx != abort_after) begin
            @(posedge clk); #1;
            req_valid = !accepted;
            req_dest  = dest;
            req_len   = len;
            case (mode)
                0:       flit_ready = 1'b1;
                1:       flit_ready = (cycles % 2 == 0);
                default: flit_ready = 1'($urandom_range(0, 1));
            endcase
            if (consumed) pld_valid = 1'b0;
            consumed = 0;
            if (!pld_valid && words.size() > 0) begin
                pld_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            pld_data = (words.size() > 0) ? words[0] : $urandom;

            @(negedge clk);
            check("busy", 64'(busy), 64'(accepted));
            check("req_ready", 64'(req_ready), 64'(!accepted));
            if (len_err) err_cycles++;
            if (prev_stall) begin
                check("hold", {30'd0, flit_valid, flit_data}, {30'd0, 1'b1, prev_data});
            end
            if (req_valid && req_ready) accepted = 1;
            if (flit_valid && flit_ready) begin
                check("flit", 64'(flit_data), 64'(exp_q[idx]));
                if (idx == 0) begin
                    head_cyc   = cycles;
                    first_flit = flit_data;
                end
                tail_cyc = cycles;
                idx++;
            end
            if (pld_valid && pld_ready) begin
                void'(words.pop_front());
                consumed = 1;
            end
            prev_stall = flit_valid && !flit_ready;
            prev_data  = flit_data;
            cycles++;
        end

        if (abort_after < 0) begin
            if (idx < n) check("timeout", 64'(idx), 64'(n));
            exp_cnt++;
            @(posedge clk); #1;
            req_valid  = 1'b0;
            pld_valid  = 1'b0;
            flit_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_req_ready", 64'(req_ready), 64'd1);
            check("idle_flit_valid", 64'(flit_valid), 64'd0);
            check("len_err_pulse", 64'(err_cycles), 64'((int'(len) > MAX_LEN) ? 1 : 0));
            check("words_left", 64'(words.size()), 64'(int'(len) - eff));
            if (mode == 0) check("throughput", 64'(tail_cyc - head_cyc), 64'(eff));
            check_pkt_count();
            $display("pkt dest=%02h len=%0d eff=%0d mode=%0d flits=%0d cycles=%0d",
                     dest, len, eff, mode, idx, cycles);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        router_addr = 8'h11;
        req_valid   = 1'b0;
        req_dest    = '0;
        req_len     = '0;
        pld_valid   = 1'b0;
        pld_data    = '0;
        flit_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_flit_valid", 64'(flit_valid), 64'd0);
        check("rst_pld_ready", 64'(pld_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rel_req_ready", 64'(req_ready), 64'd1);
        check("rel_len_err", 64'(len_err), 64'd0);
        check_pkt_count();

        send_packet(8'h23, 4'd3, 0, -1);
        send_packet(8'h11, 4'd0, 0, -1);
        check("ht_data", 64'(first_flit), 64'h3_0000_1111);
        send_packet(8'h45, 4'd5, 1, -1);
        send_packet(8'h67, 4'd12, 0, -1);
        send_packet(8'h89, 4'd15, 2, -1);

        send_packet(8'h23, 4'd4, 0, 3);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        pld_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_flit_valid", 64'(flit_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_pld_ready", 64'(pld_ready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_len_err", 64'(len_err), 64'd0);
        check_pkt_count();
        send_packet(8'h32, 4'd1, 0, -1);

        for (int p = 0; p < 30; p++) begin
            router_addr = 8'($urandom);
            send_packet(8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
